// File: rtl/lockin_tracker_pkg.sv
// rtl/lockin_tracker_pkg.sv - clock-domain bundle and lock-in tracker shared types
package common_p;
    typedef struct packed {
        logic clk;
        logic rst_n;
    } clk_dom_s;
endpackage

package clks_alot_p;
    localparam int COUNTER_WIDTH        = 16;
    localparam int DEFAULT_LOCK_COUNT   = 8;
    localparam int DEFAULT_UNLOCK_COUNT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } lockin_state_e;

    typedef struct packed {
        logic [COUNTER_WIDTH-1:0] rate;
        logic [COUNTER_WIDTH-1:0] lo;
        logic [COUNTER_WIDTH-1:0] hi;
    } lockin_window_s;
endpackage

// File: rtl/lockin_band_check.sv
// rtl/lockin_band_check.sv - saturating acceptance window and k-multiple interval compare (LOCKIN_PAUSABLE_EN)
module lockin_band_check #(
    parameter  int COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH,
    parameter  int MAX_RUN       = 4,
    localparam int RUN_WIDTH     = $clog2(MAX_RUN + 1)
) (
    input  logic [COUNTER_WIDTH-1:0] rate,
    input  logic [COUNTER_WIDTH-1:0] skew,
    input  logic [COUNTER_WIDTH-1:0] measure,
    output logic [COUNTER_WIDTH-1:0] lo,
    output logic [COUNTER_WIDTH-1:0] hi,
    output logic [COUNTER_WIDTH-1:0] limit,
    output logic                     accept,
    output logic [RUN_WIDTH-1:0]     k
);
    localparam logic [COUNTER_WIDTH-1:0] ALL_ONES = '1;

    logic [COUNTER_WIDTH:0] lo_wide;
    logic [COUNTER_WIDTH:0] hi_wide;

    // One extra bit catches the borrow/carry so both bounds saturate cleanly.
    always_comb begin
        lo_wide = {1'b0, rate} - {1'b0, skew};
        hi_wide = {1'b0, rate} + {1'b0, skew};
        lo = (lo_wide[COUNTER_WIDTH] || lo_wide[COUNTER_WIDTH-1:0] == '0)
             ? COUNTER_WIDTH'(1) : lo_wide[COUNTER_WIDTH-1:0];
        hi = hi_wide[COUNTER_WIDTH] ? ALL_ONES : hi_wide[COUNTER_WIDTH-1:0];
    end

`ifdef LOCKIN_PAUSABLE_EN
    function automatic logic [COUNTER_WIDTH-1:0] sat_add(
        input logic [COUNTER_WIDTH-1:0] a,
        input logic [COUNTER_WIDTH-1:0] b
    );
        logic [COUNTER_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[COUNTER_WIDTH] ? ALL_ONES : sum[COUNTER_WIDTH-1:0];
    endfunction

    logic [COUNTER_WIDTH-1:0] k_lo;
    logic [COUNTER_WIDTH-1:0] k_hi;

    // Smallest matching multiple wins; limit ends as MAX_RUN*hi.
    always_comb begin
        k_lo   = lo;
        k_hi   = hi;
        accept = 1'b0;
        k      = '0;
        limit  = hi;
        for (int i = 1; i <= MAX_RUN; i++) begin
            if (!accept && measure != '0 && measure >= k_lo && measure <= k_hi) begin
                accept = 1'b1;
                k      = RUN_WIDTH'(i);
            end
            limit = k_hi;
            k_lo  = sat_add(k_lo, lo);
            k_hi  = sat_add(k_hi, hi);
        end
    end
`else
    always_comb begin
        accept = (measure != '0) && (measure >= lo) && (measure <= hi);
        k      = accept ? RUN_WIDTH'(1) : '0;
        limit  = hi;
    end
`endif
endmodule

// File: rtl/monostable_full.sv
// rtl/monostable_full.sv - single-cycle pulse on the rising edge of trigger
module monostable_full
    import common_p::*;
(
    input  clk_dom_s sys_dom,
    input  logic     trigger,
    output logic     pulse
);
    logic clk;
    logic rst_n;
    logic trigger_q;

    assign clk   = sys_dom.clk;
    assign rst_n = sys_dom.rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trigger_q <= 1'b0;
        else        trigger_q <= trigger;
    end

    assign pulse = trigger && !trigger_q;
endmodule

// File: rtl/lockin_tracker.sv
// rtl/lockin_tracker.sv - CDR lock-in tracker: rate IIR, lock/unlock FSM, window publish (LOCKIN_PAUSABLE_EN)
module lockin_tracker
    import clks_alot_p::*;
    import common_p::*;
#(
    parameter  int COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH,
    parameter  int LOCK_COUNT    = DEFAULT_LOCK_COUNT,
    parameter  int UNLOCK_COUNT  = DEFAULT_UNLOCK_COUNT,
    parameter  int AVG_SHIFT     = 2,
    parameter  int MAX_RUN       = 4,
    localparam int RUN_WIDTH     = $clog2(MAX_RUN + 1)
) (
    input  clk_dom_s                 sys_dom_i,
    input  logic                     recovery_en_i,
    input  logic [COUNTER_WIDTH-1:0] nominal_rate_i,
    input  logic [COUNTER_WIDTH-1:0] skew_i,
    input  logic [COUNTER_WIDTH-1:0] current_rate_counter_i,
    input  logic                     filtered_event_i,
    output logic [COUNTER_WIDTH-1:0] tracked_rate_o,
    output logic [COUNTER_WIDTH-1:0] window_lo_o,
    output logic [COUNTER_WIDTH-1:0] window_hi_o,
    output logic                     locked_o,
    output logic                     lock_lost_o,
    output logic                     edge_accepted_o,
    output logic                     edge_rejected_o,
    output logic [RUN_WIDTH-1:0]     run_length_o
);
    logic clk;
    logic rst_n;
    assign clk   = sys_dom_i.clk;
    assign rst_n = sys_dom_i.rst_n;

    lockin_state_e            state;
    lockin_state_e            state_next;
    logic [COUNTER_WIDTH-1:0] rate;
    logic [COUNTER_WIDTH-1:0] hits;
    logic [COUNTER_WIDTH-1:0] misses;
    logic                     armed;
    logic                     accepted;
    logic                     rejected;
    logic                     lost;
    logic [RUN_WIDTH-1:0]     run_length;

    logic                     enable_rise;
    logic [COUNTER_WIDTH-1:0] lo;
    logic [COUNTER_WIDTH-1:0] hi;
    logic [COUNTER_WIDTH-1:0] limit;
    logic                     band_accept;
    logic [RUN_WIDTH-1:0]     band_k;

    monostable_full u_enable_edge (
        .sys_dom (sys_dom_i),
        .trigger (recovery_en_i),
        .pulse   (enable_rise)
    );

    lockin_band_check #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .MAX_RUN       (MAX_RUN)
    ) u_band (
        .rate    (rate),
        .skew    (skew_i),
        .measure (current_rate_counter_i),
        .lo      (lo),
        .hi      (hi),
        .limit   (limit),
        .accept  (band_accept),
        .k       (band_k)
    );

    logic                     active;
    logic                     edge_seen;
    logic                     overrun;
    logic                     hit;
    logic                     miss;
    logic                     gain_lock;
    logic                     drop_lock;
    logic [COUNTER_WIDTH-1:0] hits_inc;
    logic [COUNTER_WIDTH-1:0] misses_inc;
    logic signed [COUNTER_WIDTH:0] rate_error;
    logic [COUNTER_WIDTH-1:0] rate_step;

    // The enable edge is a load cycle, so events arriving with it are dropped.
    always_comb begin
        active     = recovery_en_i && !enable_rise && (state != IDLE);
        edge_seen  = active && filtered_event_i;
        overrun    = active && armed && !filtered_event_i && (current_rate_counter_i > limit);
        hit        = edge_seen && band_accept && (band_k == RUN_WIDTH'(1));
        miss       = (edge_seen && !band_accept) || overrun;
        hits_inc   = (&hits)   ? hits   : hits + 1'b1;
        misses_inc = (&misses) ? misses : misses + 1'b1;
        gain_lock  = (state == ACQUIRE) && hit && (hits_inc >= COUNTER_WIDTH'(LOCK_COUNT));
        drop_lock  = (state == LOCKED) && miss && (misses_inc >= COUNTER_WIDTH'(UNLOCK_COUNT));
        rate_error = $signed({1'b0, current_rate_counter_i}) - $signed({1'b0, rate});
        rate_step  = COUNTER_WIDTH'(rate_error >>> AVG_SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!recovery_en_i)   state_next = IDLE;
        else if (enable_rise) state_next = ACQUIRE;
        else if (gain_lock)   state_next = LOCKED;
        else if (drop_lock)   state_next = ACQUIRE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate       <= '0;
            hits       <= '0;
            misses     <= '0;
            armed      <= 1'b0;
            accepted   <= 1'b0;
            rejected   <= 1'b0;
            lost       <= 1'b0;
            run_length <= '0;
        end else begin
            accepted   <= edge_seen && band_accept;
            rejected   <= edge_seen && !band_accept;
            lost       <= drop_lock;
            run_length <= (edge_seen && band_accept) ? band_k : '0;
            if (!recovery_en_i) begin
                rate   <= '0;
                hits   <= '0;
                misses <= '0;
                armed  <= 1'b0;
            end else if (enable_rise || drop_lock) begin
                rate   <= nominal_rate_i;
                hits   <= '0;
                misses <= '0;
                armed  <= 1'b1;
            end else if (active) begin
                if (filtered_event_i) armed <= 1'b1;
                else if (overrun)     armed <= 1'b0;
                if (hit) begin
                    rate   <= rate + rate_step;
                    hits   <= hits_inc;
                    misses <= '0;
                end else if (miss) begin
                    misses <= misses_inc;
                    hits   <= '0;
                end
            end
        end
    end

    always_comb begin
        locked_o        = (state == LOCKED);
        tracked_rate_o  = rate;
        window_lo_o     = (state == IDLE) ? '0 : lo;
        window_hi_o     = (state == IDLE) ? '0 : hi;
        lock_lost_o     = lost;
        edge_accepted_o = accepted;
        edge_rejected_o = rejected;
        run_length_o    = run_length;
    end
endmodule

// File: tb/tb_lockin_tracker.sv
// tb/tb_lockin_tracker.sv - directed and randomized checks of lockin_tracker against a behavioural model
module tb_lockin_tracker;
    import common_p::*;

    localparam int W       = 16;
    localparam int LOCK    = 8;
    localparam int UNLOCK  = 4;
    localparam int SHIFT   = 2;
    localparam int MAX_RUN = 4;
    localparam int RW      = $clog2(MAX_RUN + 1);
    localparam int ALL     = 65535;
`ifdef LOCKIN_PAUSABLE_EN
    localparam bit PAUSABLE = 1'b1;
`else
    localparam bit PAUSABLE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    clk_dom_s      sys_dom;
    logic          recovery_en = 1'b0;
    logic [W-1:0]  nominal_rate = '0;
    logic [W-1:0]  skew = '0;
    logic [W-1:0]  counter = '0;
    logic          filtered_event = 1'b0;
    logic [W-1:0]  tracked_rate;
    logic [W-1:0]  window_lo;
    logic [W-1:0]  window_hi;
    logic          locked;
    logic          lock_lost;
    logic          edge_accepted;
    logic          edge_rejected;
    logic [RW-1:0] run_length;

    assign sys_dom = '{clk: clk, rst_n: rst_n};
    always #5 clk = ~clk;

    lockin_tracker #(
        .COUNTER_WIDTH (W),
        .LOCK_COUNT    (LOCK),
        .UNLOCK_COUNT  (UNLOCK),
        .AVG_SHIFT     (SHIFT),
        .MAX_RUN       (MAX_RUN)
    ) dut (
        .sys_dom_i              (sys_dom),
        .recovery_en_i          (recovery_en),
        .nominal_rate_i         (nominal_rate),
        .skew_i                 (skew),
        .current_rate_counter_i (counter),
        .filtered_event_i       (filtered_event),
        .tracked_rate_o         (tracked_rate),
        .window_lo_o            (window_lo),
        .window_hi_o            (window_hi),
        .locked_o               (locked),
        .lock_lost_o            (lock_lost),
        .edge_accepted_o        (edge_accepted),
        .edge_rejected_o        (edge_rejected),
        .run_length_o           (run_length)
    );

    int checks = 0;
    int errors = 0;

    // Model state: 0 idle, 1 acquiring, 2 locked.
    int m_state = 0, m_rate = 0, m_hits = 0, m_misses = 0;
    bit m_armed = 0, m_prev_en = 0;
    int e_acc = 0, e_rej = 0, e_lost = 0, e_run = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > ALL) ? ALL : v;
    endfunction

    function automatic int win_lo(input int rate, input int sk);
        return (rate - sk < 1) ? 1 : rate - sk;
    endfunction

    function automatic int win_hi(input int rate, input int sk);
        return sat(rate + sk);
    endfunction

    function automatic int verdict(input int m, input int lo, input int hi);
        int kmax;
        kmax = PAUSABLE ? MAX_RUN : 1;
        if (m == 0) return 0;
        for (int k = 1; k <= kmax; k++)
            if (m >= sat(k * lo) && m <= sat(k * hi)) return k;
        return 0;
    endfunction

    task automatic model_miss();
        m_misses = sat(m_misses + 1);
        m_hits   = 0;
        if (m_state == 2 && m_misses >= UNLOCK) begin
            m_state  = 1;
            m_rate   = nominal_rate;
            m_hits   = 0;
            m_misses = 0;
            m_armed  = 1;
            e_lost   = 1;
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_rate = 0; m_hits = 0; m_misses = 0;
        m_armed = 0; m_prev_en = 0;
    endtask

    task automatic compare_all();
        check("tracked_rate", tracked_rate, m_rate);
        check("window_lo", window_lo, (m_state == 0) ? 0 : win_lo(m_rate, skew));
        check("window_hi", window_hi, (m_state == 0) ? 0 : win_hi(m_rate, skew));
        check("locked", locked, (m_state == 2) ? 1 : 0);
        check("lock_lost", lock_lost, e_lost);
        check("edge_accepted", edge_accepted, e_acc);
        check("edge_rejected", edge_rejected, e_rej);
        check("run_length", run_length, e_run);
    endtask

    task automatic cycle(input bit en, input bit ev, input int cnt);
        int lo, hi, k, thr;
        recovery_en    = en;
        filtered_event = ev;
        counter        = W'(cnt);
        e_acc = 0; e_rej = 0; e_lost = 0; e_run = 0;
        if (!en) begin
            m_state = 0; m_rate = 0; m_hits = 0; m_misses = 0; m_armed = 0;
        end else if (!m_prev_en) begin
            m_state = 1; m_rate = nominal_rate; m_hits = 0; m_misses = 0; m_armed = 1;
        end else if (m_state != 0) begin
            lo  = win_lo(m_rate, skew);
            hi  = win_hi(m_rate, skew);
            thr = PAUSABLE ? sat(MAX_RUN * hi) : hi;
            if (ev) begin
                m_armed = 1;
                k = verdict(cnt, lo, hi);
                if (k > 0) begin
                    e_acc = 1;
                    e_run = k;
                    if (k == 1) begin
                        m_rate   = m_rate + ((cnt - m_rate) >>> SHIFT);
                        m_hits   = sat(m_hits + 1);
                        m_misses = 0;
                        if (m_state == 1 && m_hits >= LOCK) m_state = 2;
                    end
                end else begin
                    e_rej = 1;
                    model_miss();
                end
            end else if (m_armed && cnt > thr) begin
                m_armed = 0;
                model_miss();
            end
        end
        m_prev_en = en;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rate"}, tracked_rate, 0);
        check({tag, "_lo"}, window_lo, 0);
        check({tag, "_hi"}, window_hi, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_lost"}, lock_lost, 0);
        check({tag, "_acc"}, edge_accepted, 0);
        check({tag, "_rej"}, edge_rejected, 0);
        check({tag, "_run"}, run_length, 0);
    endtask

    task automatic acquire_lock();
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        for (int i = 0; i < LOCK; i++) begin
            cycle(1, 1, 100);
            cycle(1, 0, 0);
        end
    endtask

    int exp_rates[3] = '{102, 103, 104};
    bit en_r, ev_r;
    int cnt_r, dev;

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        model_reset();
        rst_n = 1'b1;
        nominal_rate = 16'd100;
        skew = 16'd10;

        cycle(0, 0, 0);
        cycle(1, 1, 100);
        check("enable_rate", tracked_rate, 100);
        check("enable_lo", window_lo, 90);
        check("enable_hi", window_hi, 110);
        check("enable_locked", locked, 0);
        check("enable_event_ignored", edge_accepted, 0);

        for (int i = 0; i < LOCK; i++) begin
            cycle(1, 1, 100);
            check("acq_accept", edge_accepted, 1);
            check("acq_locked", locked, (i == LOCK - 1) ? 1 : 0);
            cycle(1, 0, 0);
        end

        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 108);
            check("iir_rate", tracked_rate, exp_rates[i]);
            check("iir_hi", window_hi, exp_rates[i] + 10);
            cycle(1, 0, 0);
        end

        for (int i = 0; i < UNLOCK; i++) begin
            cycle(1, 1, 150);
            check("unlock_reject", edge_rejected, 1);
            check("unlock_pulse", lock_lost, (i == UNLOCK - 1) ? 1 : 0);
        end
        check("unlock_rate", tracked_rate, 100);
        check("unlock_state", locked, 0);
        cycle(1, 0, 0);
        check("lost_single_pulse", lock_lost, 0);

        acquire_lock();
        cycle(1, 1, 200);
        check("double_accept", edge_accepted, PAUSABLE ? 1 : 0);
        check("double_run", run_length, PAUSABLE ? 2 : 0);
        check("double_rate", tracked_rate, 100);
        cycle(1, 1, 100);

        // Overrun is counted once per interval, so three further misses drop lock.
        for (int i = 0; i < 3; i++) cycle(1, 0, 500);
        for (int i = 0; i < 3; i++) cycle(1, 1, 150);
        check("overrun_unlock", lock_lost, 1);

        cycle(1, 1, 0);
        check("zero_reject", edge_rejected, 1);

        for (int i = 0; i < 400; i++) begin
            en_r = m_prev_en;
            if (!m_prev_en) en_r = ($urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 59) == 0) en_r = 1'b0;
            if ($urandom_range(0, 39) == 0) skew = W'($urandom_range(0, 30));
            if ($urandom_range(0, 19) == 0) nominal_rate = W'($urandom_range(40, 200));
            ev_r = ($urandom_range(0, 2) == 0);
            if (ev_r) begin
                if ($urandom_range(0, 9) == 0) cnt_r = int'($urandom_range(0, 300));
                else begin
                    dev = int'($urandom_range(0, 40));
                    cnt_r = m_rate + dev - 20;
                    if (cnt_r < 0) cnt_r = 0;
                end
            end else begin
                cnt_r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 500)) : 0;
            end
            cycle(en_r, ev_r, cnt_r);
        end

        cycle(0, 0, 0);
        nominal_rate = 16'd5;
        skew = 16'd10;
        cycle(1, 0, 0);
        check("sat_lo", window_lo, 1);
        check("sat_lo_hi", window_hi, 15);
        cycle(0, 0, 0);
        nominal_rate = 16'hFFF8;
        skew = 16'd16;
        cycle(1, 0, 0);
        check("sat_hi", window_hi, 16'hFFFF);
        check("sat_hi_lo", window_lo, 16'hFFE8);

        nominal_rate = 16'd100;
        skew = 16'd10;
        acquire_lock();
        check("relock", locked, 1);
        rst_n = 1'b0;
        #2;
        check_zero_outputs("midlock_reset");
        model_reset();
        recovery_en = 1'b0;
        filtered_event = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(0, 0, 0);
        cycle(1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
